// File: rtl/iq_lo_pkg.sv
// Shared types and helpers for the quadrature LO generator.
// State encoding, phase index type and amplitude function.
package iq_lo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } lo_state_t;

  typedef logic [1:0] phase_t;

  function automatic int lo_amp(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/iq_lo_lut.sv
// Quarter-rate cos/sin table lookup.
// Pure combinational; the top registers the result.
module iq_lo_lut
  import iq_lo_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  phase_t                    phase,
  input  logic                      conj,
  output logic signed [DATA_W-1:0] cos_v,
  output logic signed [DATA_W-1:0] sin_v
);

  localparam logic signed [DATA_W-1:0] AMP =
    DATA_W'(lo_amp(DATA_W));

  logic signed [DATA_W-1:0] sin_raw;

  always_comb begin
    cos_v   = '0;
    sin_raw = '0;
    unique case (phase)
      2'd0:    cos_v   = AMP;
      2'd1:    sin_raw = AMP;
      2'd2:    cos_v   = -AMP;
      default: sin_raw = -AMP;
    endcase
    sin_v = conj ? -sin_raw : sin_raw;
  end

endmodule

// File: rtl/iq_lo_gen.sv
// Quadrature LO generator: fs/4 cos/sin steps with
// programmable hold, start phase, sideband and run control.
module iq_lo_gen
  import iq_lo_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int DIV_W  = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     en_i,
  input  logic                     sync_i,
  input  logic                     stop_i,
  input  logic [DIV_W-1:0]         div_i,
  input  logic [1:0]               phase_ofs_i,
  input  logic                     conj_i,
  output logic signed [DATA_W-1:0] cos_o,
  output logic signed [DATA_W-1:0] sin_o,
  output logic [1:0]               phase_o,
  output logic                     valid_o,
  output logic                     running_o
);

  lo_state_t        state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             load;

  logic signed [DATA_W-1:0] lut_cos, lut_sin;

  // Table is indexed by the next phase so a load
  // captures the new sample on the same edge.
  iq_lo_lut #(.DATA_W(DATA_W)) u_lut (
    .phase (phase_d),
    .conj  (conj_i),
    .cos_v (lut_cos),
    .sin_v (lut_sin)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    load    = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      phase_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en_i) begin
            state_d = RUN;
            phase_d = phase_ofs_i;
            div_d   = div_i;
            cnt_d   = '0;
            load    = 1'b1;
          end
        end
        RUN, HOLD: begin
          if (sync_i) begin
            state_d = en_i ? RUN : HOLD;
            phase_d = phase_ofs_i;
            div_d   = div_i;
            cnt_d   = '0;
            load    = 1'b1;
          end else if (en_i) begin
            state_d = RUN;
            if (cnt_q == div_q) begin
              cnt_d   = '0;
              phase_d = phase_q + 2'd1;
              load    = 1'b1;
            end else begin
              cnt_d = cnt_q + DIV_W'(1);
            end
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      cos_o     <= '0;
      sin_o     <= '0;
      valid_o   <= 1'b0;
      running_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      valid_o   <= load;
      running_o <= (state_d == RUN);
      if (stop_i) begin
        cos_o <= '0;
        sin_o <= '0;
      end else if (load) begin
        cos_o <= lut_cos;
        sin_o <= lut_sin;
      end
    end
  end

  assign phase_o = phase_q;

endmodule

// File: tb/tb_iq_lo_gen.sv
// Bench for iq_lo_gen: 2-bit and 8-bit instances driven
// in parallel against a step-countdown reference model.
module tb_iq_lo_gen;

  logic       clk = 1'b0;
  logic       resetn;
  logic       en, sync, stop, conj;
  logic [7:0] div;
  logic [1:0] ofs;

  logic signed [1:0] cos2, sin2;
  logic signed [7:0] cos8, sin8;
  logic [1:0]        ph2, ph8;
  logic              v2, v8, r2, r8;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  iq_lo_gen #(.DATA_W(2), .DIV_W(8)) dut2 (
    .clk(clk), .resetn(resetn), .en_i(en), .sync_i(sync),
    .stop_i(stop), .div_i(div), .phase_ofs_i(ofs),
    .conj_i(conj), .cos_o(cos2), .sin_o(sin2),
    .phase_o(ph2), .valid_o(v2), .running_o(r2)
  );

  iq_lo_gen #(.DATA_W(8), .DIV_W(8)) dut8 (
    .clk(clk), .resetn(resetn), .en_i(en), .sync_i(sync),
    .stop_i(stop), .div_i(div), .phase_ofs_i(ofs),
    .conj_i(conj), .cos_o(cos8), .sin_o(sin8),
    .phase_o(ph8), .valid_o(v8), .running_o(r8)
  );

  // Reference model: unit-amplitude cos/sin and the number
  // of enabled edges left until the next step.
  int COS_U[4] = '{1, 0, -1, 0};
  int SIN_U[4] = '{0, 1, 0, -1};
  bit m_on, m_run, m_v;
  int m_ph, m_left, m_div, m_c, m_s;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_run = 0; m_v = 0;
    m_ph = 0; m_left = 0; m_div = 0; m_c = 0; m_s = 0;
  endtask

  task automatic emit();
    m_c    = COS_U[m_ph];
    m_s    = conj ? -SIN_U[m_ph] : SIN_U[m_ph];
    m_v    = 1;
    m_left = m_div + 1;
  endtask

  task automatic model_load();
    m_on  = 1;
    m_ph  = int'(ofs);
    m_div = int'(div);
    emit();
  endtask

  task automatic model_edge();
    if (stop) begin
      m_on = 0; m_run = 0; m_v = 0;
      m_ph = 0; m_c = 0; m_s = 0;
    end else if (!m_on) begin
      m_v = 0;
      if (en) begin
        model_load();
        m_run = 1;
      end
    end else if (sync) begin
      model_load();
      m_run = en;
    end else if (en) begin
      m_run  = 1;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_ph = (m_ph + 1) % 4;
        emit();
      end else begin
        m_v = 0;
      end
    end else begin
      m_run = 0;
      m_v   = 0;
    end
  endtask

  task automatic cmp_model();
    chk("m_cos2", int'(cos2), m_c);
    chk("m_sin2", int'(sin2), m_s);
    chk("m_cos8", int'(cos8), m_c * 127);
    chk("m_sin8", int'(sin8), m_s * 127);
    chk("m_ph2", int'(ph2), m_ph);
    chk("m_ph8", int'(ph8), m_ph);
    chk("m_v2", int'(v2), int'(m_v));
    chk("m_v8", int'(v8), int'(m_v));
    chk("m_run2", int'(r2), int'(m_run));
    chk("m_run8", int'(r8), int'(m_run));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
  endtask

  typedef struct {
    bit en;
    int dv;
    int e_cos;
    int e_sin;
    bit e_v;
    int e_ph;
  } vec_t;

  vec_t tbl[12];
  int   c8[4] = '{-127, 0, 127, 0};
  int   s8[4] = '{0, 127, 0, -127};

  initial begin
    int gap;
    logic [1:0] fr_ph;
    int fr_cos;

    tbl[0]  = '{1, 4, 1, 0, 1, 0};
    tbl[1]  = '{1, 4, 1, 0, 0, 0};
    tbl[2]  = '{1, 4, 1, 0, 0, 0};
    tbl[3]  = '{1, 4, 1, 0, 0, 0};
    tbl[4]  = '{1, 4, 1, 0, 0, 0};
    tbl[5]  = '{1, 4, 0, 1, 1, 1};
    tbl[6]  = '{1, 4, 0, 1, 0, 1};
    tbl[7]  = '{1, 4, 0, 1, 0, 1};
    tbl[8]  = '{1, 4, 0, 1, 0, 1};
    tbl[9]  = '{1, 4, 0, 1, 0, 1};
    tbl[10] = '{1, 4, -1, 0, 1, 2};
    tbl[11] = '{1, 4, -1, 0, 0, 2};

    resetn = 1'b0;
    en = 0; sync = 0; stop = 0; conj = 0;
    div = '0; ofs = '0;
    model_reset();
    #2;
    chk("rst_cos2", int'(cos2), 0);
    chk("rst_sin8", int'(sin8), 0);
    chk("rst_valid", int'(v2), 0);
    chk("rst_run", int'(r8), 0);
    chk("rst_phase", int'(ph2), 0);
    #10 resetn = 1'b1;
    step();
    step();

    // fs/4 sequence at DATA_W=2, hold of 5 cycles
    for (int i = 0; i < 12; i++) begin
      en  = tbl[i].en;
      div = 8'(tbl[i].dv);
      step();
      chk($sformatf("tbl%0d_cos", i), int'(cos2), tbl[i].e_cos);
      chk($sformatf("tbl%0d_sin", i), int'(sin2), tbl[i].e_sin);
      chk($sformatf("tbl%0d_v", i), int'(v2), int'(tbl[i].e_v));
      chk($sformatf("tbl%0d_ph", i), int'(ph2), tbl[i].e_ph);
    end

    // pause at cnt=2, resume
    stop = 1; en = 0;
    step();
    stop = 0; en = 1; div = 8'd4; ofs = 2'd1;
    step();
    chk("pause_start_v", int'(v2), 1);
    step();
    step();
    en = 0;
    fr_ph  = ph8;
    fr_cos = int'(sin8);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("pause_v", int'(v8), 0);
      chk("pause_ph", int'(ph8), int'(fr_ph));
      chk("pause_sin", int'(sin8), fr_cos);
    end
    en  = 1;
    gap = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (v2) begin
        gap = k;
        break;
      end
    end
    chk("pause_resume_gap", gap, 3);

    // sync on the same edge an update is due
    repeat (4) step();
    sync = 1; ofs = 2'd3; div = 8'd1;
    step();
    sync = 0;
    chk("sync_ph", int'(ph2), 3);
    chk("sync_cos8", int'(cos8), 0);
    chk("sync_sin8", int'(sin8), -127);
    chk("sync_sin2", int'(sin2), -1);
    chk("sync_v", int'(v8), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sync_period", int'(v2), k % 2);
    end

    // stop beats sync; sync alone in IDLE ignored
    stop = 1; sync = 1; en = 1;
    step();
    chk("stop_run", int'(r2), 0);
    chk("stop_cos", int'(cos8), 0);
    chk("stop_v", int'(v8), 0);
    chk("stop_ph", int'(ph8), 0);
    stop = 0; en = 0;
    step();
    chk("idle_sync_run", int'(r2), 0);
    chk("idle_sync_v", int'(v2), 0);
    sync = 0;

    // DATA_W=8, div 0, start phase 2, lower sideband
    en = 1; div = 8'd0; ofs = 2'd2; conj = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fast_cos8", int'(cos8), c8[i % 4]);
      chk("fast_sin8", int'(sin8), s8[i % 4]);
      chk("fast_v", int'(v8), 1);
    end

    // async reset between edges
    stop = 1;
    step();
    stop = 0; conj = 0; div = 8'd2; ofs = 2'd1;
    repeat (3) step();
    #3 resetn = 1'b0;
    model_reset();
    #1;
    cmp_model();
    chk("arst_cos", int'(cos2), 0);
    chk("arst_run", int'(r8), 0);
    ofs = 2'd2;
    #1 resetn = 1'b1;
    step();
    chk("arst_first_ph", int'(ph8), 2);
    chk("arst_first_v", int'(v8), 1);
    chk("arst_first_cos", int'(cos2), -1);

    // randomized control traffic against the model
    for (int i = 0; i < 600; i++) begin
      stop = ($urandom_range(0, 24) == 0);
      sync = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 4) != 0);
      div  = 8'($urandom_range(0, 3));
      ofs  = 2'($urandom_range(0, 3));
      conj = 1'($urandom_range(0, 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule

// File: doc/iq_lo_gen.md
Name: iq_lo_gen

Overview:
- Parametrised quadrature local-oscillator generator for the IQ demodulator.
- Produces registered signed cos/sin samples at fs/4 steps (+A, 0, -A, 0 and 0, +A, 0, -A).
- Hold time per step, start phase, sideband (conjugate) and run/pause/stop control are programmable.
- Feeds the I/Q mixers; valid_o marks every sample update.

Parameters:
- DATA_W, 2: signed output width (>=2); amplitude A = 2^(DATA_W-1)-1.
- DIV_W, 8: width of the hold-count input.

Ports:
- clk  in  1  main clock
- resetn  in  1  asynchronous active-low reset
- en_i  in  1  1 = run, 0 = pause (freeze)
- sync_i  in  1  restart: reload start phase and divider
- stop_i  in  1  return to IDLE, outputs zeroed
- div_i  in  DIV_W  each step is held div_i+1 cycles
- phase_ofs_i  in  2  start phase index loaded on start/sync
- conj_i  in  1  1 = negate sin (lower sideband); sampled every cycle
- cos_o  out  DATA_W  signed cosine sample, registered
- sin_o  out  DATA_W  signed sine sample, registered
- phase_o  out  2  current phase index
- valid_o  out  1  one-cycle pulse on each sample update
- running_o  out  1  1 in RUN state

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; phase, cnt, div_q = 0.
  - cos_o=0, sin_o=0, phase_o=0, valid_o=0, running_o=0.
- Phase table (p -> cos, sin):
  - 0 -> +A, 0
  - 1 -> 0, +A
  - 2 -> -A, 0
  - 3 -> 0, -A
  - If conj_i=1, sin is negated. Values are two's complement; DATA_W=2 gives +1=01, -1=11.
- States: IDLE, RUN, HOLD. Per-cycle priority is stop_i > sync_i > en_i.
- IDLE:
  - Outputs held at 0.
  - en_i=1 -> RUN. On that edge: phase=phase_ofs_i, div_q=div_i, cnt=0, outputs loaded from table, valid_o=1.
  - Latency: first sample appears 1 cycle after en_i is sampled high.
  - sync_i alone in IDLE is ignored.
- RUN, en_i=1:
  - If cnt==div_q: cnt=0, phase=phase+1 mod 4 (3 wraps to 0), outputs updated, valid_o=1.
  - Otherwise cnt++, outputs held, valid_o=0.
  - Result: consecutive valid_o pulses are exactly div_q+1 cycles apart.
  - div_q=0 gives an update every cycle, with valid_o held high.
- RUN, en_i=0 -> HOLD:
  - cnt, phase and outputs frozen; valid_o=0.
  - HOLD + en_i=1 -> RUN, counting resumes from the frozen cnt.
- sync_i=1 in RUN or HOLD:
  - phase=phase_ofs_i, cnt=0, div_q=div_i, outputs reloaded, valid_o=1.
  - Next state is RUN if en_i=1, otherwise HOLD.
  - Takes effect even if an update was due in the same cycle.
- stop_i=1 in any state:
  - Next state IDLE; cos_o/sin_o/phase_o/cnt = 0, valid_o=0.
  - Overrides sync_i and en_i in the same cycle.
- div_i changes outside start/sync are ignored (div_q is latched).
- conj_i change is seen in sin_o at the next update only; held outputs do not change.
- running_o=1 exactly while state==RUN. It is registered and matches the state.
- Reset asserted mid-operation: immediate return to reset values. No sample is emitted until a fresh en_i after reset release.
- No output glitches: all outputs come straight from flops.

Decomposition:
- Package iq_lo_pkg holds:
  - lo_state_t enum {IDLE, RUN, HOLD}
  - phase_t (logic [1:0])
  - function lo_amp(DATA_W) returning A
- Sub-module iq_lo_lut (combinational): phase, conj and DATA_W in; cos and sin table values out. iq_lo_gen registers its outputs.

Test Plan:
- DATA_W=2, div_i=4, phase_ofs_i=0, en_i=1 from IDLE:
  - cos_o = 01,00,11,00,01... and sin_o = 00,01,00,11,00...
  - Each value held 5 cycles; valid_o pulses every 5 cycles; first pulse 1 cycle after en_i.
- DATA_W=8, div_i=0, phase_ofs_i=2, conj_i=1:
  - cos_o = -127,0,127,0 and sin_o = 0,127,0,-127, updating every cycle.
  - valid_o constantly 1.
- Pause: drop en_i for 7 cycles mid-hold at cnt=2, then raise it:
  - Outputs and phase_o frozen during the pause; no valid_o.
  - Next update arrives exactly div_q-2+1 cycles after resume.
- Sync: sync_i=1 with phase_ofs_i=3, div_i=1 while an update is due in the same cycle:
  - Next cycle phase_o=3, cos_o=0, sin_o=-A, valid_o=1.
  - Subsequent updates every 2 cycles.
- Same-cycle controls: stop_i and sync_i both 1 during RUN:
  - Next cycle IDLE; outputs 0, running_o=0, valid_o=0.
  - sync_i alone in IDLE: no change.
- Async reset mid-run (resetn low between clock edges):
  - All outputs 0 immediately.
  - After release with en_i held high: first sample 1 cycle after the first sampling edge, starting at the current phase_ofs_i.
